// File: rtl/pc_fetch_reg_pkg.sv
// Shared fetch-stage definitions: state encoding, reset vector and NOP encoding.
package pc_fetch_reg_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] MIPS_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_reg.sv
// Fetch-stage PC register and single-outstanding instruction-fetch sequencer.
// Redirects arriving mid-fetch are remembered so wrong-path data is dropped.
module pc_fetch_reg
  import pc_fetch_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = MIPS_RESET_PC,
  parameter logic [31:0] NOP_INSTR = MIPS_NOP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc_next,
  input  logic        redirect,
  input  logic        stallF,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pcplus4F,
  output logic [31:0] instrF,
  output logic        instr_validF,
  output logic        adelF
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_discard, w_discard_nxt;
  logic [31:0]  r_pend_pc, w_pend_pc_nxt;
  logic [31:0]  r_instr_buf, w_instr_buf_nxt;
  logic         r_adel, w_adel_nxt;

  logic         w_eff_discard;
  logic [31:0]  w_target;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_discard   <= 1'b0;
      r_pend_pc   <= 32'h0;
      r_instr_buf <= NOP_INSTR;
      r_adel      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_discard   <= w_discard_nxt;
      r_pend_pc   <= w_pend_pc_nxt;
      r_instr_buf <= w_instr_buf_nxt;
      r_adel      <= w_adel_nxt;
    end
  end

  // A redirect in the same cycle as data_ok counts as already recorded.
  assign w_eff_discard = r_discard | redirect;
  assign w_target      = redirect ? pc_next : r_pend_pc;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_discard_nxt   = r_discard;
    w_pend_pc_nxt   = r_pend_pc;
    w_instr_buf_nxt = r_instr_buf;
    w_adel_nxt      = r_adel;
    case (r_state)
      S_REQ: begin
        if (is_misaligned(r_pc)) begin
          w_state_nxt     = S_HOLD;
          w_instr_buf_nxt = NOP_INSTR;
          w_adel_nxt      = 1'b1;
        end else if (inst_addr_ok) begin
          w_state_nxt = S_WAIT;
          if (redirect) begin
            w_discard_nxt = 1'b1;
            w_pend_pc_nxt = pc_next;
          end
        end else if (redirect) begin
          w_pc_nxt = pc_next;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (w_eff_discard) begin
            w_pc_nxt      = w_target;
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else begin
            w_instr_buf_nxt = inst_rdata;
            w_state_nxt     = S_HOLD;
          end
        end else if (redirect) begin
          w_discard_nxt = 1'b1;
          w_pend_pc_nxt = pc_next;
        end
      end
      S_HOLD: begin
        if (redirect || !stallF) begin
          w_pc_nxt    = pc_next;
          w_state_nxt = S_REQ;
          w_adel_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  assign inst_req     = (r_state == S_REQ) && !is_misaligned(r_pc);
  assign inst_addr    = r_pc;
  assign pcF          = r_pc;
  assign pcplus4F     = r_pc + 32'd4;
  assign instrF       = r_instr_buf;
  assign instr_validF = (r_state == S_HOLD);
  assign adelF        = r_adel;

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Bench for pc_fetch_reg: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the fetch sequencer.
module tb_pc_fetch_reg;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pc_next;
  logic        redirect;
  logic        stallF;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] pcF;
  logic [31:0] pcplus4F;
  logic [31:0] instrF;
  logic        instr_validF;
  logic        adelF;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_fetch_reg dut (
    .clk          (clk),
    .resetn       (resetn),
    .pc_next      (pc_next),
    .redirect     (redirect),
    .stallF       (stallF),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .pcF          (pcF),
    .pcplus4F     (pcplus4F),
    .instrF       (instrF),
    .instr_validF (instr_validF),
    .adelF        (adelF)
  );

  // Model: a fetch is either being requested, outstanding on the bus, or
  // delivered and held; a killed fetch refetches from the latest target.
  logic        m_outstanding, m_holding, m_killed, m_adel;
  logic [31:0] m_pc, m_target, m_instr;

  task automatic model_reset();
    m_outstanding = 1'b0;
    m_holding     = 1'b0;
    m_killed      = 1'b0;
    m_adel        = 1'b0;
    m_pc          = 32'hBFC0_0000;
    m_target      = 32'h0;
    m_instr       = 32'h0;
  endtask

  task automatic model_clock();
    if (m_holding) begin
      if (redirect || !stallF) begin
        m_pc      = pc_next;
        m_holding = 1'b0;
        m_adel    = 1'b0;
      end
    end else if (m_outstanding) begin
      if (inst_data_ok) begin
        m_outstanding = 1'b0;
        if (m_killed || redirect) begin
          m_pc     = redirect ? pc_next : m_target;
          m_killed = 1'b0;
        end else begin
          m_instr   = inst_rdata;
          m_holding = 1'b1;
        end
      end else if (redirect) begin
        m_killed = 1'b1;
        m_target = pc_next;
      end
    end else if (m_pc % 4 != 0) begin
      m_holding = 1'b1;
      m_instr   = 32'h0;
      m_adel    = 1'b1;
    end else if (inst_addr_ok) begin
      m_outstanding = 1'b1;
      if (redirect) begin
        m_killed = 1'b1;
        m_target = pc_next;
      end
    end else if (redirect) begin
      m_pc = pc_next;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic exp_req;
    exp_req = !m_outstanding && !m_holding && (m_pc % 4 == 0);
    check("inst_req",     {31'd0, inst_req},     {31'd0, exp_req});
    check("inst_addr",    inst_addr,             m_pc);
    check("pcF",          pcF,                   m_pc);
    check("pcplus4F",     pcplus4F,              m_pc + 32'd4);
    check("instr_validF", {31'd0, instr_validF}, {31'd0, m_holding});
    check("adelF",        {31'd0, adelF},        {31'd0, m_adel});
    if (m_holding) check("instrF", instrF, m_instr);
  endtask

  task automatic drive(input logic rd, input logic [31:0] pcn, input logic st,
                       input logic aok, input logic dok, input logic [31:0] rdat);
    redirect     = rd;
    pc_next      = pcn;
    stallF       = st;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rdat;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] pcn;
    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    #12;
    check_model();
    check("rst_pcF",    pcF,                   32'hBFC0_0000);
    check("rst_valid",  {31'd0, instr_validF}, 32'd0);
    check("rst_adel",   {31'd0, adelF},        32'd0);
    check("rst_instrF", instrF,                32'h0);
    resetn = 1'b1;
    #1;
    check("first_req",  {31'd0, inst_req},     32'd1);
    check("first_addr", inst_addr,             32'hBFC0_0000);

    // Basic fetch with a 1-cycle bus
    drive(1'b0, 32'hBFC0_0004, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    check("req_drop", {31'd0, inst_req}, 32'd0);
    drive(1'b0, 32'hBFC0_0004, 1'b0, 1'b0, 1'b1, 32'h2408_0001);
    step();
    check("basic_valid",  {31'd0, instr_validF}, 32'd1);
    check("basic_instrF", instrF,                32'h2408_0001);
    drive(1'b0, 32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("basic_advance", pcF, 32'hBFC0_0004);

    // Stall in HOLD for three cycles
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hBFC0_0008, 1'b1, 1'b1, 1'b0, 32'h0);
      step();
      check("stall_pcF",    pcF,                   32'hBFC0_0004);
      check("stall_instrF", instrF,                32'h1234_5678);
      check("stall_req",    {31'd0, inst_req},     32'd0);
    end
    drive(1'b0, 32'hBFC0_0008, 1'b0, 1'b0, 1'b0, 32'h0);
    step();

    // Redirect in WAIT, data returns two cycles later and is dropped
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'hBFC0_0100, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step();
    check("redir_valid", {31'd0, instr_validF}, 32'd0);
    check("redir_addr",  inst_addr,             32'hBFC0_0100);

    // Redirect coincident with data_ok
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'hBFC0_0200, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step();
    check("same_pcF", pcF, 32'hBFC0_0200);

    // Two redirects while waiting: later target wins
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'hBFC0_0300, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'hBFC0_0400, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step();
    check("two_redir_pcF", pcF, 32'hBFC0_0400);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_1111);
    step();

    // Misaligned redirect target
    drive(1'b1, 32'hBFC0_0102, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("mis_req", {31'd0, inst_req}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("mis_valid",  {31'd0, instr_validF}, 32'd1);
    check("mis_adel",   {31'd0, adelF},        32'd1);
    check("mis_instrF", instrF,                32'h0);
    drive(1'b0, 32'hBFC0_0010, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("mis_clear", {31'd0, adelF}, 32'd0);

    // Reset asserted while a fetch is outstanding
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    resetn = 1'b0;
    #1;
    model_reset();
    check_model();
    check("rst_wait_pcF", pcF, 32'hBFC0_0000);
    #1;
    resetn = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("rst_wait_req", {31'd0, inst_req}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      pcn = $urandom;
      if ($urandom_range(0, 15) != 0) pcn[1:0] = 2'b00;
      drive($urandom_range(0, 4) == 0, pcn, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1,
            m_holding ? 1'b0 : ($urandom_range(0, 2) == 0),
            $urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
